udm_mac_accumulator: RTL and testbench

- Downstream consumer of the UDM_8x8 approximate multiplier inside an APTPU processing element.
- Accepts operand pairs over a valid/ready stream and forms each product with one UDM_8x8 instance.
- Registers the product, accumulates a dot product, and emits the sum when the beat tagged last is consumed.
- Output is a one-entry result register with backpressure; it feeds the array's drain/output path.

---
 rtl/udm_mac_accumulator_pkg.sv | 56 +++++
 rtl/udm_mac_accumulator_udm.sv | 36 +++
 rtl/udm_mac_accumulator.sv | 153 +++++++++++++++
 tb/tb_udm_mac_accumulator.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/udm_mac_accumulator_pkg.sv
// ---------------------------------------------------------------------------
// udm_mac_accumulator_pkg
//   Shared definitions for the UDM multiply-accumulate processing element:
//   default widths, the 2x2 underdesigned multiplier digit, and the
//   accumulator add with carry-out detection and optional clamping.
// ---------------------------------------------------------------------------
package udm_mac_accumulator_pkg;

   localparam int WIDTH_DEF     = 8;
   localparam int ACC_WIDTH_DEF = 24;
   localparam int CNT_W_DEF     = 8;

   // Widest accumulator the shared add helper supports (exclusive upper bound).
   localparam int MAX_ACC_W     = 64;

   // Result of one accumulator add: resolved value plus overflow flag.
   typedef struct packed {
      logic                 ovf;
      logic [MAX_ACC_W-1:0] sum;
   } acc_add_t;

   // 2x2 underdesigned multiplier digit: exact except 3*3, which yields 7
   // so the digit product always fits in 3 bits.
   function automatic logic [2:0] udm2x2(input logic [1:0] a, input logic [1:0] b);
      logic [2:0] r;
      case ({a, b})
         4'b1111: r = 3'd7;
         default: r = {1'b0, a} * {1'b0, b};
      endcase
      return r;
   endfunction

   // Add two w-bit values (held in MAX_ACC_W-bit containers, upper bits zero).
   // Overflow is the carry out of bit w-1. With sat set the result clamps to
   // w'all-ones on overflow, otherwise it wraps modulo 2^w.
   function automatic acc_add_t acc_add(
      input logic [MAX_ACC_W-1:0] a,
      input logic [MAX_ACC_W-1:0] b,
      input logic [6:0]           w,
      input logic                 sat
   );
      logic [MAX_ACC_W:0] full;
      logic [MAX_ACC_W:0] mask;
      acc_add_t           r;
      full  = {1'b0, a} + {1'b0, b};
      mask  = ({{MAX_ACC_W{1'b0}}, 1'b1} << w) - {{MAX_ACC_W{1'b0}}, 1'b1};
      r.ovf = full[w];
      if (r.ovf && sat) begin
         r.sum = mask[MAX_ACC_W-1:0];
      end else begin
         r.sum = full[MAX_ACC_W-1:0] & mask[MAX_ACC_W-1:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/udm_mac_accumulator_udm.sv
// ---------------------------------------------------------------------------
// udm_8x8
//   Underdesigned (approximate) WIDTH x WIDTH unsigned multiplier. The
//   operands are split into 2-bit digits; every digit pair goes through the
//   approximate 2x2 block and the partial products are summed exactly. With
//   WIDTH = 8 this is the UDM_8x8 structure (four 4x4 blocks of four 2x2).
//
//   Ports:
//     a  in   WIDTH    multiplicand, unsigned
//     b  in   WIDTH    multiplier, unsigned
//     p  out  2*WIDTH  approximate product (combinational)
// ---------------------------------------------------------------------------
module udm_8x8
   import udm_mac_accumulator_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH-1:0] p
);

   localparam int DIGITS = WIDTH / 2;
   localparam int PW     = 2 * WIDTH;

   // Sum of shifted 2x2 digit products; only the digit multiply is approximate.
   always_comb begin
      p = {PW{1'b0}};
      for (int i = 0; i < DIGITS; i++) begin
         for (int j = 0; j < DIGITS; j++) begin
            p = p + (PW'(udm2x2(a[2*i +: 2], b[2*j +: 2])) << (2 * (i + j)));
         end
      end
   end

endmodule

// File: rtl/udm_mac_accumulator.sv
// ---------------------------------------------------------------------------
// udm_mac_accumulator
//   Dot-product engine of an APTPU processing element. Operand pairs arrive
//   on a valid/ready stream, are multiplied by one UDM_8x8 approximate
//   multiplier, registered (stage 1), then accumulated (stage 2). When the
//   beat tagged last is accumulated, the finished sum, its beat count and an
//   overflow flag load a one-entry result register with backpressure.
//
//   Ports:
//     clk        in   1          clock, rising edge
//     rst_n      in   1          asynchronous active-low reset
//     in_valid   in   1          operand beat valid
//     in_ready   out  1          beat can be accepted this cycle
//     in_a       in   WIDTH      activation operand, unsigned
//     in_b       in   WIDTH      weight operand, unsigned
//     in_last    in   1          beat is the final term of the dot product
//     out_valid  out  1          result register holds an unconsumed result
//     out_ready  in   1          downstream accepts the result
//     out_acc    out  ACC_WIDTH  completed dot product
//     out_count  out  CNT_W      beats in that dot product (saturating)
//     out_ovf    out  1          carry-out or clamp occurred in that product
//
//   ACC_WIDTH must be at least 2*WIDTH and below 64.
// ---------------------------------------------------------------------------
module udm_mac_accumulator
   import udm_mac_accumulator_pkg::*;
#(
   parameter int WIDTH     = WIDTH_DEF,
   parameter int ACC_WIDTH = ACC_WIDTH_DEF,
   parameter int CNT_W     = CNT_W_DEF,
   parameter int SAT       = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   input  logic                 in_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_WIDTH-1:0] out_acc,
   output logic [CNT_W-1:0]     out_count,
   output logic                 out_ovf
);

   localparam logic SAT_EN = (SAT != 0);

   // Stage 1 (product) state
   logic                 p_valid;
   logic                 p_last;
   logic [ACC_WIDTH-1:0] p_reg;

   // Stage 2 (accumulator) state
   logic [ACC_WIDTH-1:0] acc;
   logic [CNT_W-1:0]     cnt;
   logic                 ovf_acc;

   // Combinational helpers
   logic [2*WIDTH-1:0]   prod;
   logic                 stall;
   logic                 accept;
   logic                 advance;
   acc_add_t             add_res;
   logic [ACC_WIDTH-1:0] sum;
   logic                 sum_ovf;
   logic [CNT_W-1:0]     cnt_inc;
   logic                 add_unused;

   udm_8x8 #(
      .WIDTH (WIDTH)
   ) u_udm (
      .a (in_a),
      .b (in_b),
      .p (prod)
   );

   // Handshake, accumulate arithmetic and saturating beat count.
   // Only a last beat waiting on a full, unconsumed result register stalls;
   // non-last beats always move into the accumulator.
   always_comb begin
      stall   = p_valid & p_last & out_valid & ~out_ready;
      accept  = in_valid & ~stall;
      advance = p_valid & ~stall;
      add_res = acc_add(MAX_ACC_W'(acc), MAX_ACC_W'(p_reg), 7'(ACC_WIDTH), SAT_EN);
      sum     = add_res.sum[ACC_WIDTH-1:0];
      sum_ovf = add_res.ovf;
      if (cnt == {CNT_W{1'b1}}) begin
         cnt_inc = cnt;
      end else begin
         cnt_inc = cnt + CNT_W'(1);
      end
   end

   // Upper container bits of the shared add are always zero here.
   assign add_unused = ^add_res.sum[MAX_ACC_W-1:ACC_WIDTH];

   assign in_ready = ~stall;

   // Stage 1: register the approximate product of each accepted beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_valid <= 1'b0;
         p_last  <= 1'b0;
         p_reg   <= {ACC_WIDTH{1'b0}};
      end else if (accept) begin
         p_valid <= 1'b1;
         p_last  <= in_last;
         p_reg   <= ACC_WIDTH'(prod);
      end else if (!stall) begin
         p_valid <= 1'b0;
      end
   end

   // Stage 2: accumulate; a last beat restarts the sum in the same cycle so
   // the next dot product follows without a bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc     <= {ACC_WIDTH{1'b0}};
         cnt     <= {CNT_W{1'b0}};
         ovf_acc <= 1'b0;
      end else if (advance) begin
         if (p_last) begin
            acc     <= {ACC_WIDTH{1'b0}};
            cnt     <= {CNT_W{1'b0}};
            ovf_acc <= 1'b0;
         end else begin
            acc     <= sum;
            cnt     <= cnt_inc;
            ovf_acc <= ovf_acc | sum_ovf;
         end
      end
   end

   // Result register: loads on a last beat (which may coincide with the
   // previous result draining), otherwise clears when consumed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_acc   <= {ACC_WIDTH{1'b0}};
         out_count <= {CNT_W{1'b0}};
         out_ovf   <= 1'b0;
      end else if (advance && p_last) begin
         out_valid <= 1'b1;
         out_acc   <= sum;
         out_count <= cnt_inc;
         out_ovf   <= ovf_acc | sum_ovf;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_udm_mac_accumulator.sv
// Scoreboard bench: three instances share one input stream
// (24-bit saturating, 16-bit saturating, 16-bit wrapping); expected results
// are queued per instance at stimulus time and popped by the monitor.
module tb_udm_mac_accumulator;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       in_valid = 1'b0;
   logic [7:0] in_a = 8'd0;
   logic [7:0] in_b = 8'd0;
   logic       in_last = 1'b0;
   logic       out_ready = 1'b1;

   logic        rdy0, v0, ovf0;
   logic [23:0] acc0;
   logic [7:0]  cnt0;
   logic        rdy1, v1, ovf1;
   logic [15:0] acc1;
   logic [7:0]  cnt1;
   logic        rdy2, v2, ovf2;
   logic [15:0] acc2;
   logic [7:0]  cnt2;

   udm_mac_accumulator #(.WIDTH(8), .ACC_WIDTH(24), .CNT_W(8), .SAT(1)) dut_w24 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
      .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(v0),
      .out_ready(out_ready), .out_acc(acc0), .out_count(cnt0), .out_ovf(ovf0));

   udm_mac_accumulator #(.WIDTH(8), .ACC_WIDTH(16), .CNT_W(8), .SAT(1)) dut_s16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
      .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(v1),
      .out_ready(out_ready), .out_acc(acc1), .out_count(cnt1), .out_ovf(ovf1));

   udm_mac_accumulator #(.WIDTH(8), .ACC_WIDTH(16), .CNT_W(8), .SAT(0)) dut_w16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2),
      .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(v2),
      .out_ready(out_ready), .out_acc(acc2), .out_count(cnt2), .out_ovf(ovf2));

   typedef struct {
      logic [23:0] acc;
      logic [7:0]  cnt;
      logic        ovf;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];

   int n_checks = 0;
   int n_fail   = 0;
   int last_wait = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic push3(input logic [23:0] a0, input logic [23:0] a1, input logic [23:0] a2,
                        input logic [7:0] c, input logic o0, input logic o1, input logic o2);
      exp_t e;
      e.cnt = c;
      e.acc = a0; e.ovf = o0; q0.push_back(e);
      e.acc = a1; e.ovf = o1; q1.push_back(e);
      e.acc = a2; e.ovf = o2; q2.push_back(e);
   endtask

   task automatic push_all(input logic [23:0] a, input logic [7:0] c, input logic o);
      push3(a, a, a, c, o, o, o);
   endtask

   task automatic pop_check(input int id, input logic [23:0] acc, input logic [7:0] cnt,
                            input logic ovf);
      exp_t e;
      logic have;
      have = 1'b0;
      e.acc = 24'd0; e.cnt = 8'd0; e.ovf = 1'b0;
      case (id)
         0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
         1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
         default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
      endcase
      n_checks++;
      if (!have) begin
         n_fail++;
         $display("FAIL result_dut%0d: unexpected result acc=0x%0h cnt=%0d ovf=%0b",
                  id, acc, cnt, ovf);
      end else if (acc !== e.acc || cnt !== e.cnt || ovf !== e.ovf) begin
         n_fail++;
         $display("FAIL result_dut%0d: got acc=0x%0h cnt=%0d ovf=%0b, required acc=0x%0h cnt=%0d ovf=%0b",
                  id, acc, cnt, ovf, e.acc, e.cnt, e.ovf);
      end
   endtask

   // Monitor: consume results on handshake and check held results stay put.
   logic        hold_prev = 1'b0;
   logic [32:0] hold_val  = 33'd0;
   always @(negedge clk) begin
      if (rst_n) begin
         if (hold_prev) check("hold_stable", {31'd0, v0, ovf0, cnt0, acc0}, {31'd0, 1'b1, hold_val});
         if (v0 && out_ready) pop_check(0, acc0, cnt0, ovf0);
         if (v1 && out_ready) pop_check(1, {8'h00, acc1}, cnt1, ovf1);
         if (v2 && out_ready) pop_check(2, {8'h00, acc2}, cnt2, ovf2);
         hold_prev <= v0 && !out_ready;
         hold_val  <= {ovf0, cnt0, acc0};
      end else begin
         hold_prev <= 1'b0;
      end
   end

   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last);
      logic ok;
      int   n;
      in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
      ok = 1'b0; n = 0;
      while (!ok && n < 200) begin
         @(negedge clk);
         ok = rdy0 && rdy1 && rdy2;
         @(posedge clk);
         #1;
         n++;
      end
      in_valid = 1'b0;
      last_wait = n;
      if (!ok) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: got in_ready=0 for 200 cycles, required acceptance");
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_out_valid", {61'd0, v0, v1, v2}, 64'd0);
      check("reset_out_acc", {8'd0, acc0, acc1, acc2}, 64'd0);
      check("reset_count_ovf", {37'd0, cnt0, cnt1, cnt2, ovf0, ovf1, ovf2}, 64'd0);
      @(negedge clk) rst_n = 1'b1;
      idle(1);

      // Two-beat dot product: 2*5 + 0x10*0x10 = 10 + 256 = 266
      push_all(24'd266, 8'd2, 1'b0);
      send(8'd2, 8'd5, 1'b0);
      send(8'h10, 8'h10, 1'b1);
      @(negedge clk);
      @(negedge clk);
      check("pulse_high", {63'd0, v0}, 64'd1);
      @(negedge clk);
      check("pulse_low", {63'd0, v0}, 64'd0);
      idle(1);

      // Single beat 3*3 -> approximate 7
      push_all(24'd7, 8'd1, 1'b0);
      send(8'd3, 8'd3, 1'b1);

      // Back-to-back single-beat dot products, no bubbles
      push_all(24'd10, 8'd1, 1'b0);
      send(8'd2, 8'd5, 1'b1);
      check("no_bubble_1", 64'(last_wait), 64'd1);
      push_all(24'd16, 8'd1, 1'b0);
      send(8'd4, 8'd4, 1'b1);
      check("no_bubble_2", 64'(last_wait), 64'd1);
      idle(4);

      // Backpressure: hold first result, second last beat stalls stage 1
      out_ready = 1'b0;
      push_all(24'd10, 8'd1, 1'b0);
      send(8'd2, 8'd5, 1'b1);
      push_all(24'd16, 8'd1, 1'b0);
      send(8'd4, 8'd4, 1'b1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("stall_in_ready", {63'd0, rdy0}, 64'd0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      push_all(24'd7, 8'd1, 1'b0);
      send(8'd3, 8'd3, 1'b1);
      check("release_accept", 64'(last_wait), 64'd1);
      idle(4);

      // Overflow: 4 x (0x80*0x80 = 0x4000) = 0x10000
      push3(24'h010000, 24'h00FFFF, 24'h000000, 8'd4, 1'b0, 1'b1, 1'b1);
      send(8'h80, 8'h80, 1'b0);
      send(8'h80, 8'h80, 1'b0);
      send(8'h80, 8'h80, 1'b0);
      send(8'h80, 8'h80, 1'b1);
      idle(4);

      // Asynchronous reset mid dot product discards the partial sum
      send(8'd1, 8'd2, 1'b0);
      send(8'd3, 8'd1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("midreset_out_valid", {61'd0, v0, v1, v2}, 64'd0);
      check("midreset_out_acc", {8'd0, acc0, acc1, acc2}, 64'd0);
      check("midreset_count_ovf", {37'd0, cnt0, cnt1, cnt2, ovf0, ovf1, ovf2}, 64'd0);
      @(negedge clk) rst_n = 1'b1;
      idle(1);
      push_all(24'd10, 8'd1, 1'b0);
      send(8'd2, 8'd5, 1'b1);

      // Drain with a bounded wait
      for (int k = 0; k < 50 && (q0.size() + q1.size() + q2.size()) != 0; k++) idle(1);
      check("queues_drained", 64'(q0.size() + q1.size() + q2.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
